// File: rtl/line_prefetcher.sv
// Line prefetcher: fetches one 320-pixel framebuffer row per display line pair into
// a two-bank line buffer and replays it 2x-scaled. Optional underrun flag: LINE_PREFETCHER_UNDERRUN_EN.
module line_prefetcher #(
  parameter int          HA_STA    = 149,
  parameter int          VA_STA    = 44,
  parameter logic [16:0] VRAM_BASE = 17'h00000
) (
  input  logic        clkPixel,
  input  logic        reset,
  input  logic [11:0] h_count,
  input  logic [11:0] v_count,
  input  logic        hsync_in,
  input  logic        vsync_in,
  input  logic        blank_in,
  output logic        vram_req,
  output logic [16:0] vram_addr,
  input  logic        vram_ack,
  input  logic [7:0]  vram_data,
  output logic [7:0]  pixel,
  output logic        hsync_out,
  output logic        vsync_out,
  output logic        blank_out,
  output logic        underrun,
  input  logic        underrun_clr
);

  localparam logic [11:0] HA_STA12 = 12'(HA_STA);
  localparam logic [11:0] HA_FIRST = 12'(HA_STA + 1);
  localparam logic [11:0] HA_LAST  = 12'(HA_STA + 640);
  localparam logic [11:0] VA_STA12 = 12'(VA_STA);
  localparam logic [11:0] VA_FIRST = 12'(VA_STA + 1);
  localparam logic [11:0] VA_LAST  = 12'(VA_STA + 480);

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_FETCH = 2'd1;
  localparam logic [1:0] ST_DONE  = 2'd2;

  function automatic logic [7:0] blank_mask(input logic [7:0] data, input logic show);
    return show ? data : 8'h00;
  endfunction

  logic [1:0]  state;
  logic [7:0]  row;
  logic [8:0]  col;
  logic        wr_en;

  logic [11:0] h_off;
  logic [11:0] v_line;
  logic [11:0] v_rel;
  logic        act_h;
  logic        act_v;
  logic        act_p0;
  logic        rd_bank_p0;
  logic [8:0]  rd_col_p0;
  logic        trigger;
  logic [7:0]  trig_row;
  logic [16:0] row_base;

  logic [7:0]  bank0 [0:319];
  logic [7:0]  bank1 [0:319];

  logic [7:0]  rd_data_p1;
  logic        vld_p1;
  logic        hsync_p1;
  logic        vsync_p1;
  logic        blank_p1;

  logic        unused_bits;

  assign h_off  = h_count - HA_FIRST;
  assign v_line = v_count - VA_FIRST;
  assign v_rel  = v_count - VA_STA12;

  assign act_h      = (h_count >= HA_FIRST) && (h_count <= HA_LAST);
  assign act_v      = (v_count >= VA_FIRST) && (v_count <= VA_LAST);
  assign act_p0     = act_h && act_v;
  assign rd_col_p0  = h_off[9:1];
  assign rd_bank_p0 = v_line[1];

  // Row r is fetched during line VA_STA+2r, one line ahead of its first display line.
  assign trigger  = (h_count == 12'd0) && (v_count >= VA_STA12) &&
                    (v_rel <= 12'd478) && !v_rel[0];
  assign trig_row = v_rel[8:1];
  assign row_base = VRAM_BASE + {1'b0, trig_row, 8'd0} + {3'b000, trig_row, 6'd0};

  assign wr_en = (state == ST_FETCH) && vram_ack;

  assign unused_bits = ^{h_off[11:10], h_off[0], v_line[11:2], v_line[0], v_rel[11:9]};

  always_ff @(posedge clkPixel or posedge reset) begin
    if (reset) begin
      state     <= ST_IDLE;
      row       <= 8'd0;
      col       <= 9'd0;
      vram_req  <= 1'b0;
      vram_addr <= 17'd0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (trigger) begin
            state     <= ST_FETCH;
            row       <= trig_row;
            col       <= 9'd0;
            vram_addr <= row_base;
            vram_req  <= 1'b1;
          end
        end
        ST_FETCH: begin
          if (vram_ack) begin
            if (col == 9'd319) begin
              state    <= ST_DONE;
              vram_req <= 1'b0;
            end else begin
              col       <= col + 9'd1;
              vram_addr <= vram_addr + 17'd1;
            end
          end
        end
        ST_DONE: state <= ST_IDLE;
        default: state <= ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge clkPixel) begin
    if (wr_en) begin
      if (row[0]) bank1[col] <= vram_data;
      else        bank0[col] <= vram_data;
    end
  end

  // Stage p0 -> p1: line buffer read, timing captured alongside.
  always_ff @(posedge clkPixel) begin
    if (act_p0) rd_data_p1 <= rd_bank_p0 ? bank1[rd_col_p0] : bank0[rd_col_p0];
  end

  always_ff @(posedge clkPixel or posedge reset) begin
    if (reset) begin
      vld_p1    <= 1'b0;
      hsync_p1  <= 1'b0;
      vsync_p1  <= 1'b0;
      blank_p1  <= 1'b1;
      hsync_out <= 1'b0;
      vsync_out <= 1'b0;
      blank_out <= 1'b1;
      pixel     <= 8'h00;
    end else begin
      vld_p1    <= act_p0;
      hsync_p1  <= hsync_in;
      vsync_p1  <= vsync_in;
      blank_p1  <= blank_in;
      // Stage p1 -> output: blanked pixels forced to zero.
      hsync_out <= hsync_p1;
      vsync_out <= vsync_p1;
      blank_out <= blank_p1;
      pixel     <= blank_mask(rd_data_p1, vld_p1 && !blank_p1);
    end
  end

`ifdef LINE_PREFETCHER_UNDERRUN_EN
  logic ur_event;

  // Still fetching when the first active pixel of a visible line is about to be read.
  assign ur_event = (state != ST_IDLE) && (h_count == HA_STA12) && act_v;

  always_ff @(posedge clkPixel or posedge reset) begin
    if (reset)             underrun <= 1'b0;
    else if (ur_event)     underrun <= 1'b1;
    else if (underrun_clr) underrun <= 1'b0;
  end
`else
  logic clr_unused;

  assign clr_unused = underrun_clr;
  assign underrun   = 1'b0;
`endif

endmodule
